individual_scorer: RTL and testbench

INDIVIDUAL_SCORER -- requirements
Module: individual_scorer

---
 rtl/individual_scorer.sv | 191 +++++++++++++++++++
 tb/tb_individual_scorer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/individual_scorer.sv
// Self-test scorer for a LANES-wide array of 2x2 unsigned multipliers: drives LFSR or
// exhaustive stimulus, compares candidate outputs to the true products, counts bad bits.
module individual_scorer #(
  parameter int LANES = 16,
  parameter int SUM_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [15:0]      num_vectors,
  input  logic [63:0]      seed,
  output logic [LANES-1:0] a1,
  output logic [LANES-1:0] a0,
  output logic [LANES-1:0] b1,
  output logic [LANES-1:0] b0,
  input  logic [LANES-1:0] y3,
  input  logic [LANES-1:0] y2,
  input  logic [LANES-1:0] y1,
  input  logic [LANES-1:0] y0,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] err_sum,
  output logic             perfect
);

  localparam int VW = 4 * LANES;
  localparam int CW = $clog2(VW + 1);
  localparam int AW = ((SUM_W > CW) ? SUM_W : CW) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q;
  logic            mode_q;
  logic [15:0]     rem_q;
  logic [63:0]     lfsr_q;
  logic [3:0]      cnt_q;
  logic            drain_q;
  logic [VW-1:0]   stim_q;
  logic            busy_q;
  logic            done_q;
  logic            perfect_q;

  logic [VW-1:0]   mis_d, mis_q;
  logic            mis_vld_q;
  logic [CW-1:0]   pop_c;
  logic [AW-1:0]   sum_wide;
  logic [SUM_W-1:0] err_sum_d, err_sum_q;
  logic [SUM_W-1:0] sat_max;

  logic [63:0]     seed_eff;
  logic [VW-1:0]   seed_vec;
  logic [VW-1:0]   lfsr_vec;
  logic            start_acc;

  // Taps 64,63,61,60 in 1-based numbering are bits 63,62,60,59.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  function automatic logic [VW-1:0] ctr_vec(input logic [3:0] k);
    return {{LANES{k[3]}}, {LANES{k[2]}}, {LANES{k[1]}}, {LANES{k[0]}}};
  endfunction

  assign seed_eff  = (seed == 64'd0) ? 64'h1 : seed;
  assign seed_vec  = seed_eff[63 -: VW];
  assign lfsr_vec  = lfsr_q[63 -: VW];
  assign start_acc = (state_q == IDLE) && start;

  // Control FSM; stimulus register is only non-zero while in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      rem_q     <= '0;
      lfsr_q    <= '0;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      stim_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      perfect_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            cnt_q     <= 4'd1;
            drain_q   <= 1'b0;
            busy_q    <= 1'b1;
            perfect_q <= 1'b0;
            lfsr_q    <= lfsr_step(seed_eff);
            if (num_vectors == 16'd0) begin
              state_q <= DRAIN;
              stim_q  <= '0;
            end else begin
              state_q <= RUN;
              rem_q   <= num_vectors - 16'd1;
              stim_q  <= mode ? ctr_vec(4'd0) : seed_vec;
            end
          end
        end
        RUN: begin
          if (rem_q == 16'd0) begin
            state_q <= DRAIN;
            stim_q  <= '0;
            drain_q <= 1'b0;
          end else begin
            rem_q  <= rem_q - 16'd1;
            stim_q <= mode_q ? ctr_vec(cnt_q) : lfsr_vec;
            lfsr_q <= lfsr_step(lfsr_q);
            cnt_q  <= cnt_q + 4'd1;
          end
        end
        DRAIN: begin
          // Two drain cycles let the last vector clear both pipeline stages.
          if (drain_q) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            perfect_q <= (err_sum_q == '0);
          end else begin
            drain_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a1 = stim_q[4*LANES-1 -: LANES];
  assign a0 = stim_q[3*LANES-1 -: LANES];
  assign b1 = stim_q[2*LANES-1 -: LANES];
  assign b0 = stim_q[LANES-1:0];

  // Stage 1: true product per lane, XOR against the candidate response.
  always_comb begin
    logic [3:0] prod;
    mis_d = '0;
    prod  = '0;
    for (int i = 0; i < LANES; i++) begin
      prod = 4'({a1[i], a0[i]}) * 4'({b1[i], b0[i]});
      mis_d[3*LANES+i] = prod[3] ^ y3[i];
      mis_d[2*LANES+i] = prod[2] ^ y2[i];
      mis_d[LANES+i]   = prod[1] ^ y1[i];
      mis_d[i]         = prod[0] ^ y0[i];
    end
  end

  // Stage 2: popcount and saturating accumulate.
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < VW; i++) begin
      pop_c = pop_c + CW'(mis_q[i]);
    end
  end

  assign sat_max  = '1;
  assign sum_wide = AW'(err_sum_q) + AW'(pop_c);

  always_comb begin
    err_sum_d = err_sum_q;
    if (start_acc) begin
      err_sum_d = '0;
    end else if (mis_vld_q) begin
      err_sum_d = (sum_wide > AW'(sat_max)) ? sat_max : sum_wide[SUM_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q     <= '0;
      mis_vld_q <= 1'b0;
      err_sum_q <= '0;
    end else begin
      mis_q     <= mis_d;
      mis_vld_q <= (state_q == RUN);
      err_sum_q <= err_sum_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err_sum = err_sum_q;
  assign perfect = perfect_q;

endmodule

// File: tb/tb_individual_scorer.sv
// Bench for individual_scorer: a bench-side 2x2 candidate (golden / stuck / faulty)
// with a vector-level reference model, a directed table, random runs and a mid-run reset.
module tb_individual_scorer;

  localparam int LANES = 16;

  logic             clk;
  logic             rst_n;
  logic             start, s8_start;
  logic             mode;
  logic [15:0]      num_vectors;
  logic [63:0]      seed;
  logic [LANES-1:0] a1, a0, b1, b0;
  logic [LANES-1:0] y3, y2, y1, y0;
  logic             busy, done, perfect;
  logic [23:0]      err_sum;

  logic [LANES-1:0] sa1, sa0, sb1, sb0;
  logic [LANES-1:0] ones_w;
  logic             s_busy, s_done, s_perfect;
  logic [7:0]       s_err_sum;

  int               cand_sel;
  logic [15:0]      f_lmask;
  logic [3:0]       f_trig;
  logic [3:0]       f_flip;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  individual_scorer #(.LANES(LANES), .SUM_W(24)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .num_vectors(num_vectors), .seed(seed),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0),
    .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .busy(busy), .done(done), .err_sum(err_sum), .perfect(perfect)
  );

  assign ones_w = '1;

  individual_scorer #(.LANES(LANES), .SUM_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .mode(mode),
    .num_vectors(num_vectors), .seed(seed),
    .a1(sa1), .a0(sa0), .b1(sb1), .b0(sb0),
    .y3(ones_w), .y2(ones_w), .y1(ones_w), .y0(ones_w),
    .busy(s_busy), .done(s_done), .err_sum(s_err_sum), .perfect(s_perfect)
  );

  // candidate: 0 golden, 1 stuck-0, 2 stuck-1, 3 golden with flips on selected lanes/inputs
  function automatic logic [3:0] cand_lane(input logic [1:0] a, input logic [1:0] b,
                                           input int sel, input logic hit, input logic [3:0] flip);
    logic [3:0] p;
    p = 4'(a) * 4'(b);
    case (sel)
      1:       return 4'h0;
      2:       return 4'hF;
      3:       return hit ? (p ^ flip) : p;
      default: return p;
    endcase
  endfunction

  always_comb begin
    y3 = '0; y2 = '0; y1 = '0; y0 = '0;
    for (int i = 0; i < LANES; i++) begin
      {y3[i], y2[i], y1[i], y0[i]} = cand_lane({a1[i], a0[i]}, {b1[i], b0[i]}, cand_sel,
                                               f_lmask[i] && ({a1[i], a0[i], b1[i], b0[i]} == f_trig),
                                               f_flip);
    end
  end

  // reference model: total wrong bits over a run, from the stimulus rules
  function automatic longint model_err(input bit m, input int n, input logic [63:0] sd,
                                       input int sel, input logic [15:0] lmask,
                                       input logic [3:0] trig, input logic [3:0] flip);
    logic [63:0] s;
    longint e;
    int a, b, prod;
    s = (sd == 64'd0) ? 64'd1 : sd;
    e = 0;
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i < LANES; i++) begin
        if (m) begin
          a = (j % 16) / 4;
          b = (j % 16) % 4;
        end else begin
          a = 2 * int'(s[48+i]) + int'(s[32+i]);
          b = 2 * int'(s[16+i]) + int'(s[i]);
        end
        prod = a * b;
        case (sel)
          1: e += $countones(prod);
          2: e += 4 - $countones(prod);
          3: if (lmask[i] && (a * 4 + b == int'(trig))) e += $countones(flip);
          default: ;
        endcase
      end
      s = (s << 1) | 64'(^(s & 64'hD800_0000_0000_0000));
    end
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: called on a negedge; returns on a negedge
  task automatic run_one(input string tag, input bit m, input int n, input logic [63:0] sd,
                         input int sel, input int restart_at, input bit sat,
                         input longint exp_err, input longint exp_sat);
    int cyc, busy_cnt;
    bit got;
    longint held_err;
    bit held_perf;
    cand_sel = sel; mode = m; num_vectors = 16'(n); seed = sd;
    start = 1'b1; s8_start = sat;
    cyc = 0; busy_cnt = 0; got = 0;
    while (!got && cyc < n + 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0; s8_start = 1'b0;
        mode = ~m; num_vectors = 16'd3; seed = ~sd;
      end
      if (restart_at > 0 && cyc == restart_at) start = 1'b1;
      else if (restart_at > 0 && cyc == restart_at + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) got = 1;
    end
    check({tag, " done_latency"}, got ? cyc : -1, n + 3);
    check({tag, " busy_cycles"}, busy_cnt, n + 3);
    check({tag, " err_sum"}, err_sum, (exp_err > 64'hFF_FFFF) ? 64'hFF_FFFF : exp_err);
    check({tag, " perfect"}, perfect, (exp_err == 0) ? 1 : 0);
    if (sat) check({tag, " sat_err_sum"}, s_err_sum, exp_sat);
    held_err = err_sum; held_perf = perfect;
    @(posedge clk); #1;
    check({tag, " done_pulse_width"}, done, 0);
    check({tag, " busy_after_done"}, busy, 0);
    check({tag, " err_sum_held"}, err_sum, held_err);
    check({tag, " perfect_held"}, perfect, held_perf);
    @(negedge clk);
  endtask

  typedef struct {
    string       tag;
    bit          m;
    int          n;
    logic [63:0] sd;
    int          sel;
    logic [15:0] lmask;
    logic [3:0]  trig;
    logic [3:0]  flip;
    int          restart_at;
    bit          sat;
    longint      exp_err;
    longint      exp_sat;
  } vec_t;

  vec_t tbl[7];

  initial begin
    bit saw_done;
    rst_n = 1'b0; start = 1'b0; s8_start = 1'b0; mode = 1'b0;
    num_vectors = '0; seed = '0; cand_sel = 0;
    f_lmask = '0; f_trig = '0; f_flip = '0;

    tbl[0] = '{"zero_vectors", 1'b1, 0, 64'd0, 1, 16'h0, 4'h0, 4'h0, 0, 1'b0, 0, 0};
    tbl[1] = '{"golden_lfsr", 1'b0, 1000, 64'hDEADBEEF_01234567, 0, 16'h0, 4'h0, 4'h0, 0, 1'b0, 0, 0};
    tbl[2] = '{"stuck0_exh", 1'b1, 16, 64'd0, 1, 16'h0, 4'h0, 4'h0, 0, 1'b0, 224, 0};
    tbl[3] = '{"stuck1_exh", 1'b1, 16, 64'd0, 2, 16'h0, 4'h0, 4'h0, 0, 1'b1, 800, 255};
    tbl[4] = '{"start_while_busy", 1'b1, 16, 64'd0, 1, 16'h0, 4'h0, 4'h0, 5, 1'b0, 224, 0};
    tbl[5] = '{"stuck1_wrap", 1'b1, 32, 64'd0, 2, 16'h0, 4'h0, 4'h0, 0, 1'b0, 1600, 0};
    // seed 0 -> 1: vector j has only lane j with a=0,b=1; lanes 0..7 flip 2 bits each
    tbl[6] = '{"seed0_fault", 1'b0, 8, 64'd0, 3, 16'h00FF, 4'b0001, 4'b0011, 0, 1'b0, 16, 0};

    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err_sum", err_sum, 0);
    check("reset perfect", perfect, 0);
    check("reset stimulus", {a1, a0, b1, b0}, 0);
    check("reset sat err_sum", s_err_sum, 0);

    // start on the first edge after reset release
    rst_n = 1'b1;
    for (int t = 0; t < 7; t++) begin
      f_lmask = tbl[t].lmask; f_trig = tbl[t].trig; f_flip = tbl[t].flip;
      run_one(tbl[t].tag, tbl[t].m, tbl[t].n, tbl[t].sd, tbl[t].sel, tbl[t].restart_at,
              tbl[t].sat, tbl[t].exp_err, tbl[t].exp_sat);
    end

    for (int r = 0; r < 8; r++) begin
      bit rm;
      int rn, rsel;
      logic [63:0] rsd;
      longint e;
      rm = 1'($urandom_range(0, 1));
      rn = $urandom_range(1, 48);
      rsel = (r < 4) ? 3 : $urandom_range(0, 3);
      rsd = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      f_lmask = 16'($urandom); f_trig = 4'($urandom_range(0, 15)); f_flip = 4'($urandom_range(1, 15));
      e = model_err(rm, rn, rsd, rsel, f_lmask, f_trig, f_flip);
      run_one($sformatf("random%0d", r), rm, rn, rsd, rsel, 0, 1'b0, e, 0);
    end

    // reset in the middle of a long run
    cand_sel = 2; mode = 1'b0; num_vectors = 16'd1000; seed = 64'hDEADBEEF_01234567;
    start = 1'b1;
    saw_done = 0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (499) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    check("midreset busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset err_sum", err_sum, 0);
    check("midreset perfect", perfect, 0);
    check("midreset stimulus", {a1, a0, b1, b0}, 0);
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check("midreset no_done", saw_done, 0);
    rst_n = 1'b1;
    run_one("after_reset", 1'b1, 20, 64'd0, 1, 0, 1'b0, 224, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
